// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder, CHUNK bits per clock, LSB chunk first.
// Optional subtract mode enabled by defining SEQ_CHUNK_ADDER_SUB_EN (adds the Sub port).
`default_nettype none

module seq_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    generate
        if ((CHUNK < 1) ? 1'b1 : ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0))) begin : g_bad_params
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic [IDX_W-1:0]   idx;

    logic               accept;
    logic               last_chunk;
    logic               b_inv;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   sum_chunk;
    logic               chunk_cout;
    logic               msb_cin;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
    assign b_inv = Sub;
`else
    assign b_inv = 1'b0;
`endif

    assign a_chunk    = a_q[int'(idx) * CHUNK +: CHUNK];
    assign b_chunk    = b_q[int'(idx) * CHUNK +: CHUNK];
    assign {chunk_cout, sum_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    // Carry into the chunk's top bit, recovered from the sum bit; on the last chunk this is the carry into bit WIDTH-1.
    assign msb_cin    = sum_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];
    assign last_chunk = (idx == IDX_W'(N - 1));
    assign accept     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last_chunk) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? CALC : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Subtraction is folded in at capture time: B and Cin are stored pre-inverted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
        end else if (accept) begin
            a_q   <= A;
            b_q   <= B ^ {WIDTH{b_inv}};
            carry <= Cin ^ b_inv;
            idx   <= '0;
        end else if (state == CALC) begin
            S[int'(idx) * CHUNK +: CHUNK] <= sum_chunk;
            carry <= chunk_cout;
            if (last_chunk) begin
                idx  <= '0;
                Cout <= chunk_cout;
                V    <= msb_cin ^ chunk_cout;
            end else begin
                idx  <= idx + IDX_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
